// File: rtl/zigzag_buf.sv
// zigzag_buf: ping-pong 8x8 zigzag reorder stage (forward: raster->zigzag, inverse: zigzag->raster).
// Define ZIGZAG_LAST_EN to add dout_last, which marks the 64th output of every block.
module zigzag_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          mode,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
`ifdef ZIGZAG_LAST_EN
  ,
  output logic          dout_last
`endif
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Zigzag position -> raster address.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Raster position -> zigzag index.
  localparam logic [5:0] ZZINV [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,  2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,  9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54, 20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61, 35, 36, 48, 49, 57, 58, 62, 63
  };

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          wr_bank, rd_bank;
  logic [5:0]    wr_cnt, rd_cnt;
  logic [1:0]    bank_mode;
  logic [DW-1:0] mem [128];

  logic          wr_fire;
  logic          rd_avail;
  logic          out_load;
  logic [5:0]    rd_addr;

  assign din_ready = (state_q[wr_bank] == EMPTY) || (state_q[wr_bank] == FILLING);
  assign wr_fire   = din_valid && din_ready;
  assign rd_avail  = (state_q[rd_bank] == FULL) || (state_q[rd_bank] == DRAINING);
  assign out_load  = rd_avail && (!dout_valid || dout_ready);
  assign rd_addr   = bank_mode[rd_bank] ? ZZINV[rd_cnt] : ZZ[rd_cnt];

  // Write and read always target different banks, so both updates can apply on one edge.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (wr_fire)
      state_d[wr_bank] = (wr_cnt == 6'd63) ? FULL : FILLING;
    if (out_load)
      state_d[rd_bank] = (rd_cnt == 6'd63) ? EMPTY : DRAINING;
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= '{EMPTY, EMPTY};
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      bank_mode  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd0)
          bank_mode[wr_bank] <= mode;
        if (wr_cnt == 6'd63)
          wr_bank <= ~wr_bank;
      end
      if (out_load) begin
        dout       <= mem[{rd_bank, rd_addr}];
        dout_valid <= 1'b1;
        rd_cnt     <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63)
          rd_bank <= ~rd_bank;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // NOTE: the sample store has no reset; bank states keep unwritten entries from being read.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[{wr_bank, wr_cnt}] <= din;
  end

`ifdef ZIGZAG_LAST_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      dout_last <= 1'b0;
    else if (out_load)
      dout_last <= (rd_cnt == 6'd63);
    else if (dout_ready)
      dout_last <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_zigzag_buf.sv
// tb_zigzag_buf: directed + randomized bench for zigzag_buf against a queue-based block model.
// Honours ZIGZAG_LAST_EN when the design is built with it.
module tb_zigzag_buf;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          nrst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          mode;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
`ifdef ZIGZAG_LAST_EN
  logic          dout_last;
`endif

  zigzag_buf #(.DW(DW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .mode       (mode),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef ZIGZAG_LAST_EN
    ,
    .dout_last  (dout_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            zz [64];
  int            zzinv [64];
  exp_t          expq [$];
  logic [DW-1:0] blk [64];
  int            blk_n = 0;
  logic          blk_mode = 1'b0;
  logic [DW-1:0] in_log [$];
  logic [DW-1:0] obs_q [$];
  logic [DW-1:0] src_q [$];
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_dout;
  bit            last_in_fire;
  bit            chk_ready = 1'b0;
  int            in_fires, out_fires, first_fire, last_fire;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zigzag order from the diagonal walk: even anti-diagonals run bottom-left to top-right.
  function automatic void build_tables();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      for (int i = 0; i <= hi - lo; i++) begin
        int row = (s % 2 == 0) ? hi - i : lo + i;
        zz[k] = row * 8 + (s - row);
        k++;
      end
    end
    for (int j = 0; j < 64; j++) zzinv[zz[j]] = j;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic m);
    if (blk_n == 0) blk_mode = m;
    blk[blk_n] = d;
    in_log.push_back(d);
    blk_n++;
    if (blk_n == 64) begin
      for (int k = 0; k < 64; k++) begin
        exp_t e;
        e.d    = blk_mode ? blk[zzinv[k]] : blk[zz[k]];
        e.last = (k == 63);
        expq.push_back(e);
      end
      blk_n = 0;
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      check("hold_valid", dout_valid, 1);
      check("hold_data", dout, prev_dout);
    end
    if (chk_ready) check("stream_din_ready", din_ready, 1);
    if (dout_valid && dout_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", dout_valid, 0);
      end else begin
        exp_t e = expq.pop_front();
        check("dout", dout, e.d);
`ifdef ZIGZAG_LAST_EN
        check("dout_last", dout_last, e.last);
`endif
      end
      obs_q.push_back(dout);
      out_fires++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    last_in_fire = din_valid && din_ready;
    if (last_in_fire) begin
      model_accept(din, mode);
      in_fires++;
    end
    prev_hold = dout_valid && !dout_ready;
    prev_dout = dout;
    @(posedge clk);
    #1;
  endtask

  // src: 0 = incrementing, 1 = random, 2 = from src_q.
  task automatic feed(input logic m, input int n, input int src, input bit sparse, input bit rnd_ready);
    int sent = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (sent < n && guard < 4000) begin
      din_valid = sparse ? tog : 1'b1;
      tog = ~tog;
      mode = (blk_n == 0) ? m : 1'($urandom);
      case (src)
        0:       din = DW'(sent);
        1:       din = DW'($urandom);
        default: din = src_q[sent];
      endcase
      if (rnd_ready) dout_ready = 1'($urandom);
      cycle();
      if (last_in_fire) sent++;
      guard++;
    end
    if (sent < n) check("feed_timeout", sent, n);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    dout_ready = 1'b1;
    din_valid  = 1'b0;
    while ((expq.size() > 0 || dout_valid) && guard < 1000) begin
      cycle();
      guard++;
    end
    check("drain_left", expq.size(), 0);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #2;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
`ifdef ZIGZAG_LAST_EN
    check("rst_dout_last", dout_last, 0);
`endif
    expq.delete();
    blk_n     = 0;
    prev_hold = 1'b0;
    din_valid = 1'b1;
    din       = DW'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hold_valid", dout_valid, 0);
    @(negedge clk);
    nrst      = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rst_release_ready", din_ready, 1);
    check("rst_release_valid", dout_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int zz_lit [10]  = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    int inv_lit [10] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4};
    logic [DW-1:0] orig [$];

    nrst = 1'b1; din = '0; din_valid = 1'b0; mode = 1'b0; dout_ready = 1'b1;
    build_tables();
    #1;
    do_reset();

    // Forward block with din = 0..63, plus first-output latency.
    obs_q.delete();
    feed(1'b0, 64, 0, 1'b0, 1'b0);
    check("fwd_lat_before", dout_valid, 0);
    cycle();
    check("fwd_lat_after", dout_valid, 1);
    drain();
    check("fwd_count", obs_q.size(), 64);
    for (int i = 0; i < 10; i++) check("fwd_literal", obs_q[i], zz_lit[i]);

    // Inverse block with din = 0..63.
    obs_q.delete();
    feed(1'b1, 64, 0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 10; i++) check("inv_literal", obs_q[i], inv_lit[i]);

    // Forward then inverse restores the original block.
    in_log.delete(); obs_q.delete();
    feed(1'b0, 64, 1, 1'b0, 1'b0);
    drain();
    orig  = in_log;
    src_q = obs_q;
    obs_q.delete();
    feed(1'b1, 64, 2, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 64; i++) check("roundtrip", obs_q[i], orig[i]);

    // Three back-to-back blocks, modes 0/1/0, no input or output bubbles.
    out_fires = 0; first_fire = -1; chk_ready = 1'b1;
    feed(1'b0, 64, 1, 1'b0, 1'b0);
    feed(1'b1, 64, 1, 1'b0, 1'b0);
    feed(1'b0, 64, 1, 1'b0, 1'b0);
    chk_ready = 1'b0;
    drain();
    check("stream_outputs", out_fires, 192);
    check("stream_no_bubble", last_fire - first_fire, 191);

    // Backpressure: output stalled, input continuous with mode wiggling mid-block.
    in_fires = 0; dout_ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 140; i++) begin
      din  = DW'($urandom);
      mode = 1'($urandom);
      cycle();
    end
    check("bp_accepts", in_fires, 128);
    check("bp_din_ready", din_ready, 0);
    check("bp_dout_valid", dout_valid, 1);
    drain();

    // Sparse input, incrementing per accepted sample.
    obs_q.delete();
    feed(1'b0, 64, 0, 1'b1, 1'b0);
    check("sparse_lat_before", dout_valid, 0);
    cycle();
    check("sparse_lat_after", dout_valid, 1);
    drain();
    for (int i = 0; i < 10; i++) check("sparse_literal", obs_q[i], zz_lit[i]);

    // Random modes, data and downstream stalls.
    for (int b = 0; b < 4; b++) feed(1'($urandom), 64, 1, 1'($urandom), 1'b1);
    drain();

    // Reset after 30 samples; the next block must be clean.
    feed(1'b0, 30, 1, 1'b0, 1'b0);
    do_reset();
    obs_q.delete();
    feed(1'b1, 64, 1, 1'b0, 1'b0);
    drain();
    check("post_reset_count", obs_q.size(), 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zigzag_buf.md
# zigzag_buf

Parametrised, double-buffered 8x8 zigzag reorder stage for the JPEG encoder datapath. It sits between the quantiser and the entropy coder and accepts one coefficient per accepted handshake. It buffers a full 64-sample block and emits it in zigzag order (forward) or restores raster order from zigzag (inverse). Unlike the previous single-direction, valid-only stage, it has a configurable data width, per-block mode selection, and valid/ready backpressure on both sides, with ping-pong banks for sustained one-sample-per-cycle throughput.

## Interface
- DW, 8, coefficient width in bits; legal range 1..32.
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- din  in  DW  input sample.
- din_valid  in  1  input sample valid.
- din_ready  out  1  block can accept a sample this cycle.
- mode  in  1  0 = forward (raster in, zigzag out); 1 = inverse (zigzag in, raster out). Sampled with the first sample of each block.
- dout  out  DW  output sample.
- dout_valid  out  1  output sample valid.
- dout_ready  in  1  downstream accepts dout this cycle.
- dout_last  out  1  only with ZIGZAG_LAST_EN; marks the 64th output of a block.

## Operation
- Transfer occurs on an edge where valid and ready are both high, on either side.
- Storage is two banks (A/B) of 64 x DW. Each bank has a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY, plus a latched mode bit.
- Write side:
  - Accepted samples go to the write bank at address wr_cnt (0..63, wraps).
  - The first accepted sample latches mode for that bank; mode changes mid-block are ignored.
  - When the 64th sample is accepted, the bank goes FULL, the write pointer toggles to the other bank, and wr_cnt goes to 0.
- din_ready = 1 when the current write bank is EMPTY or FILLING, otherwise 0. It is combinational from registered state only and does not depend on din_valid.
- Read side:
  - Banks drain in the order they were filled.
  - Read address is ZZ[rd_cnt] in forward mode, where ZZ is the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,…,63).
  - Read address is ZZINV[rd_cnt] in inverse mode (0,1,5,6,14,15,27,28,2,4,…,63).
  - Both tables are constant ROMs internal to the block.
- dout is driven from an output register. The next sample is loaded when !dout_valid or dout_ready.
- When rd_cnt 63 is loaded into the output register, that bank goes EMPTY and the read side moves to the other bank.
- Simultaneous events:
  - One bank completing its fill while the other completes its drain on the same edge: both transitions take effect.
  - A bank that becomes EMPTY on edge N may be written from cycle N+1.
- dout_valid and dout must stay stable while dout_valid=1 and dout_ready=0.
- Reset, asynchronous at any time:
  - Both banks go EMPTY; counters go to 0; any partial or buffered blocks are discarded.
  - dout=0, dout_valid=0, dout_last=0.
  - din_ready reads 1 as soon as nrst is released. No sample is accepted while nrst=0.
- Memory contents are not reset.

## Timing
- Latency: if the 64th input of a block is accepted on edge N, the first output of that block is valid after edge N+1 (dout_valid high in cycle N+1), provided the read side is idle.
- Throughput: 1 sample/cycle sustained on both sides with din_valid=1 and dout_ready=1. din_ready never deasserts in that case.
- Backpressure: with dout_ready=0, at most 128 samples plus 1 in the output register are held. din_ready falls after the 128th accepted sample.
- Gaps: din_valid may deassert on any cycle, including alternate cycles, without affecting ordering.

## Configuration
- ZIGZAG_LAST_EN:
  - Defined: adds the dout_last port, asserted with the 64th output of each block and subject to the same hold rules as dout.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Forward block: mode=0, din=0..63 continuous, dout_ready=1 -> dout sequence 0,1,8,16,9,2,3,10,17,24,…,63. dout_last (if enabled) only on 63.
- Inverse block: mode=1, din=0..63 -> dout 0,1,5,6,14,15,27,28,2,4,…,63. Forward followed by inverse on the same data returns din unchanged.
- Streaming: 3 blocks back-to-back with mode alternating 0/1/0 -> din_ready stays 1 throughout; 192 outputs with no bubbles after the first; each block uses its own latched mode.
- Backpressure: dout_ready=0 with continuous input -> din_ready=0 after 128 accepts; dout held stable. Releasing dout_ready yields correct order for both blocks.
- Sparse input: din_valid toggling every cycle, din incrementing per accepted sample, DW=12 -> correct zigzag order; first dout_valid one cycle after the 64th accept.
- Reset mid-block: nrst pulsed after 30 accepted samples -> dout_valid=0 and din_ready=1 after release. The next 64 samples produce one correct block with no stale data.
